// File: rtl/memory_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter_pkg
// Description : Shared types and constants for the fetch/data memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_arbiter_pkg;

    // Arbiter FSM: at most one memory access outstanding at any time
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    // Identity of the requester that most recently won the memory port
    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_DM = 1'b1
    } grant_t;

    // Instruction fetches always read a full word
    localparam logic [3:0] BYTE_EN_ALL = 4'b1111;

endpackage : memory_arbiter_pkg
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter
// Description : Shares one memory port between instruction fetch (IF) and
//               data memory (DM) requesters. Round-robin on ties, a single
//               outstanding access, combinational request/response routing.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    // fetch requester
    input  logic            if_req_valid,
    output logic            if_req_ready,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_resp_valid,
    output logic [XLEN-1:0] if_rdata,
    // data requester
    input  logic            dm_req_valid,
    output logic            dm_req_ready,
    input  logic [XLEN-1:0] dm_addr,
    input  logic [XLEN-1:0] dm_wdata,
    input  logic [3:0]      dm_read_byte_en,
    input  logic [3:0]      dm_write_byte_en,
    output logic            dm_resp_valid,
    output logic [XLEN-1:0] dm_rdata,
    // shared memory port
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_read_byte_en,
    output logic [3:0]      mem_write_byte_en,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_rdata
);

    state_t r_state;
    state_t w_state_next;
    grant_t r_last_grant;
    grant_t w_last_grant_next;

    grant_t w_win;
    logic   w_win_valid;

    // Two-way round-robin: a lone requester wins outright; on a tie the
    // requester that did not win last time goes first. Evaluated every cycle
    // so a requester withdrawing before acceptance hands over immediately.
    assign w_win = (if_req_valid && dm_req_valid)
                 ? ((r_last_grant == GRANT_IF) ? GRANT_DM : GRANT_IF)
                 : (dm_req_valid ? GRANT_DM : GRANT_IF);
    assign w_win_valid = if_req_valid || dm_req_valid;

    // State and last-grant registers; reset abandons any outstanding access
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_DM;
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_last_grant_next;
        end
    end

    // Next-state plus request/response routing; every output is held at zero
    // during reset so nothing leaks out while the block is being cleared
    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        mem_req_valid     = 1'b0;
        mem_addr          = '0;
        mem_wdata         = '0;
        mem_read_byte_en  = 4'b0000;
        mem_write_byte_en = 4'b0000;
        if_req_ready      = 1'b0;
        dm_req_ready      = 1'b0;
        if_resp_valid     = 1'b0;
        if_rdata          = '0;
        dm_resp_valid     = 1'b0;
        dm_rdata          = '0;

        if (!reset) begin
            case (r_state)
                IDLE: begin
                    mem_req_valid = w_win_valid;
                    if (w_win == GRANT_DM) begin
                        mem_addr          = dm_addr;
                        mem_wdata         = dm_wdata;
                        mem_read_byte_en  = dm_read_byte_en;
                        mem_write_byte_en = dm_write_byte_en;
                        dm_req_ready      = dm_req_valid && mem_req_ready;
                    end else begin
                        mem_addr          = if_addr;
                        mem_read_byte_en  = BYTE_EN_ALL;
                        if_req_ready      = if_req_valid && mem_req_ready;
                    end
                    if (w_win_valid && mem_req_ready) begin
                        w_state_next      = (w_win == GRANT_DM) ? BUSY_DM : BUSY_IF;
                        w_last_grant_next = w_win;
                    end
                end
                BUSY_IF: begin
                    if (mem_resp_valid) begin
                        if_resp_valid = 1'b1;
                        if_rdata      = mem_rdata;
                        w_state_next  = IDLE;
                    end
                end
                BUSY_DM: begin
                    if (mem_resp_valid) begin
                        dm_resp_valid = 1'b1;
                        dm_rdata      = mem_rdata;
                        w_state_next  = IDLE;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

endmodule : memory_arbiter
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_arbiter
// Description : Self-checking bench for memory_arbiter: directed scenarios
//               followed by randomized traffic, all outputs compared every
//               cycle against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            if_req_valid;
    logic            if_req_ready;
    logic [XLEN-1:0] if_addr;
    logic            if_resp_valid;
    logic [XLEN-1:0] if_rdata;
    logic            dm_req_valid;
    logic            dm_req_ready;
    logic [XLEN-1:0] dm_addr;
    logic [XLEN-1:0] dm_wdata;
    logic [3:0]      dm_read_byte_en;
    logic [3:0]      dm_write_byte_en;
    logic            dm_resp_valid;
    logic [XLEN-1:0] dm_rdata;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_read_byte_en;
    logic [3:0]      mem_write_byte_en;
    logic            mem_resp_valid;
    logic [XLEN-1:0] mem_rdata;

    memory_arbiter #(.XLEN(XLEN)) dut (
        .clk              (clk),
        .reset            (reset),
        .if_req_valid     (if_req_valid),
        .if_req_ready     (if_req_ready),
        .if_addr          (if_addr),
        .if_resp_valid    (if_resp_valid),
        .if_rdata         (if_rdata),
        .dm_req_valid     (dm_req_valid),
        .dm_req_ready     (dm_req_ready),
        .dm_addr          (dm_addr),
        .dm_wdata         (dm_wdata),
        .dm_read_byte_en  (dm_read_byte_en),
        .dm_write_byte_en (dm_write_byte_en),
        .dm_resp_valid    (dm_resp_valid),
        .dm_rdata         (dm_rdata),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_read_byte_en (mem_read_byte_en),
        .mem_write_byte_en(mem_write_byte_en),
        .mem_resp_valid   (mem_resp_valid),
        .mem_rdata        (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: list of accesses in flight (1 = fetch, 2 = data)
    // and which requester took the port most recently.
    int outstanding[$];
    bit last_was_if;
    bit m_if_acc;
    bit m_dm_acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed 0x%0h required 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        reset            = 1'b0;
        if_req_valid     = 1'b0;
        if_addr          = '0;
        dm_req_valid     = 1'b0;
        dm_addr          = '0;
        dm_wdata         = '0;
        dm_read_byte_en  = 4'b0000;
        dm_write_byte_en = 4'b0000;
        mem_req_ready    = 1'b0;
        mem_resp_valid   = 1'b0;
        mem_rdata        = '0;
    endtask

    // Mid-cycle: compare every output against what the model expects
    task automatic settle();
        bit any;
        bit pick_dm;
        int owner;
        #4;
        any     = if_req_valid || dm_req_valid;
        pick_dm = (if_req_valid && dm_req_valid) ? last_was_if : dm_req_valid;
        m_if_acc = 1'b0;
        m_dm_acc = 1'b0;
        if (reset) begin
            check("rst_mem_req_valid", mem_req_valid, 0);
            check("rst_if_req_ready", if_req_ready, 0);
            check("rst_dm_req_ready", dm_req_ready, 0);
            check("rst_if_resp_valid", if_resp_valid, 0);
            check("rst_dm_resp_valid", dm_resp_valid, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_mem_wdata", mem_wdata, 0);
            check("rst_mem_rd_en", mem_read_byte_en, 0);
            check("rst_mem_wr_en", mem_write_byte_en, 0);
            check("rst_if_rdata", if_rdata, 0);
            check("rst_dm_rdata", dm_rdata, 0);
        end else if (outstanding.size() == 0) begin
            m_if_acc = if_req_valid && !pick_dm && mem_req_ready;
            m_dm_acc = pick_dm && mem_req_ready;
            check("mem_req_valid", mem_req_valid, any);
            check("if_req_ready", if_req_ready, m_if_acc);
            check("dm_req_ready", dm_req_ready, m_dm_acc);
            check("if_resp_idle", if_resp_valid, 0);
            check("dm_resp_idle", dm_resp_valid, 0);
            if (any) begin
                check("mem_addr", mem_addr, pick_dm ? dm_addr : if_addr);
                check("mem_rd_en", mem_read_byte_en, pick_dm ? dm_read_byte_en : 4'hF);
                check("mem_wr_en", mem_write_byte_en, pick_dm ? dm_write_byte_en : 4'h0);
                if (pick_dm) check("mem_wdata", mem_wdata, dm_wdata);
            end
        end else begin
            owner = outstanding[0];
            check("busy_mem_req_valid", mem_req_valid, 0);
            check("busy_if_req_ready", if_req_ready, 0);
            check("busy_dm_req_ready", dm_req_ready, 0);
            check("if_resp_valid", if_resp_valid, mem_resp_valid && owner == 1);
            check("dm_resp_valid", dm_resp_valid, mem_resp_valid && owner == 2);
            if (mem_resp_valid && owner == 1) check("if_rdata", if_rdata, mem_rdata);
            if (mem_resp_valid && owner == 2 && dm_write_byte_en == 4'h0)
                check("dm_rdata", dm_rdata, mem_rdata);
        end
    endtask

    // Clock edge: advance the model with the inputs held over the edge
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            outstanding.delete();
            last_was_if = 1'b0;
        end else if (outstanding.size() == 0) begin
            if (m_if_acc) begin
                outstanding.push_back(1);
                last_was_if = 1'b1;
            end else if (m_dm_acc) begin
                outstanding.push_back(2);
                last_was_if = 1'b0;
            end
        end else if (mem_resp_valid) begin
            void'(outstanding.pop_front());
        end
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        settle(); tick();
        reset = 1'b0;
    endtask

    task automatic respond(input logic [XLEN-1:0] data);
        mem_resp_valid = 1'b1;
        mem_rdata      = data;
        settle(); tick();
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        outstanding.delete();
        last_was_if = 1'b0;
        do_reset();

        // Single fetch with one-cycle memory latency
        if_req_valid = 1'b1; if_addr = 32'h10; mem_req_ready = 1'b1;
        settle();
        check("fetch_addr", mem_addr, 32'h10);
        check("fetch_rd_en", mem_read_byte_en, 4'b1111);
        tick();
        if_req_valid = 1'b0;
        mem_resp_valid = 1'b1; mem_rdata = 32'h00500093;
        settle();
        check("fetch_resp", if_resp_valid, 1);
        check("fetch_rdata", if_rdata, 32'h00500093);
        tick();
        mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
        if_req_valid = 1'b1; if_addr = 32'h14;
        settle();
        check("fetch_back_idle", mem_req_valid, 1);
        tick();

        // Ties after reset alternate IF, DM, IF
        do_reset();
        mem_req_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            if_req_valid = 1'b1; if_addr = 32'h100 + t;
            dm_req_valid = 1'b1; dm_addr = 32'h200 + t; dm_read_byte_en = 4'hF;
            settle();
            check("tie_if_ready", if_req_ready, (t != 1));
            check("tie_dm_ready", dm_req_ready, (t == 1));
            tick();
            respond($urandom);
        end

        // Store forwarded and acknowledged only on the data side
        do_reset();
        dm_req_valid = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF;
        dm_write_byte_en = 4'b1111; mem_req_ready = 1'b1;
        settle();
        check("store_wr_en", mem_write_byte_en, 4'b1111);
        check("store_wdata", mem_wdata, 32'hDEADBEEF);
        tick();
        dm_req_valid = 1'b0;
        mem_resp_valid = 1'b1;
        settle();
        check("store_dm_resp", dm_resp_valid, 1);
        check("store_if_resp", if_resp_valid, 0);
        tick();
        mem_resp_valid = 1'b0;
        settle();
        check("store_resp_once", dm_resp_valid, 0);
        tick();

        // Memory backpressure holds the fetch in IDLE
        clear_inputs();
        if_req_valid = 1'b1; if_addr = 32'h80;
        for (int t = 0; t < 3; t++) begin
            settle();
            check("bp_if_ready", if_req_ready, 0);
            check("bp_mem_valid", mem_req_valid, 1);
            tick();
        end
        mem_req_ready = 1'b1;
        settle();
        check("bp_grant", if_req_ready, 1);
        tick();
        if_req_valid = 1'b0;
        respond(32'h1234);

        // Reset during a data access, then a stray late response
        clear_inputs();
        dm_req_valid = 1'b1; dm_addr = 32'h44; mem_req_ready = 1'b1;
        settle(); tick();
        dm_req_valid = 1'b0;
        reset = 1'b1;
        settle(); tick();
        reset = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hBAD;
        settle();
        check("late_dm_resp", dm_resp_valid, 0);
        tick();
        mem_resp_valid = 1'b0;
        if_req_valid = 1'b1; dm_req_valid = 1'b1;
        settle();
        check("post_rst_tie", if_req_ready, 1);
        tick();
        if_req_valid = 1'b0;

        // Memory withholds the fetch response for 20 cycles
        mem_req_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            settle();
            check("stuck_mem_valid", mem_req_valid, 0);
            check("stuck_resp", if_resp_valid | dm_resp_valid, 0);
            tick();
        end
        mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE;
        settle();
        check("stuck_release", if_resp_valid, 1);
        tick();
        mem_resp_valid = 1'b0;
        dm_req_valid = 1'b0;

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            if (!if_req_valid || m_if_acc) begin
                if_req_valid = 1'($urandom_range(0, 1));
                if_addr      = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                if_req_valid = 1'b0;
            end
            if (!dm_req_valid || m_dm_acc) begin
                dm_req_valid     = 1'($urandom_range(0, 1));
                dm_addr          = $urandom;
                dm_wdata         = $urandom;
                dm_read_byte_en  = 4'($urandom);
                dm_write_byte_en = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                dm_req_valid = 1'b0;
            end
            mem_req_ready  = ($urandom_range(0, 3) != 0);
            mem_resp_valid = ($urandom_range(0, 2) == 0);
            mem_rdata      = $urandom;
            settle();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_memory_arbiter
`default_nettype wire
